// File: rtl/vga_timing_gen_if.sv
// Output bundle of vga_timing_gen: pixel strobe, syncs, coordinates and
// game-logic strobes. Colour outputs exist only when TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          pixel_en;
    logic          Hsync;
    logic          Vsync;
    logic          displayON;
    logic [XW-1:0] Xpixel;
    logic [YW-1:0] Ypixel;
    logic          line_start;
    logic          frame_start;
    logic          vblank_start;
`ifdef TEST_PATTERN_EN
    logic [3:0]    Red;
    logic [3:0]    Green;
    logic [3:0]    Blue;
`endif

    modport master (
        output pixel_en, Hsync, Vsync, displayON, Xpixel, Ypixel,
               line_start, frame_start, vblank_start
`ifdef TEST_PATTERN_EN
        , output Red, Green, Blue
`endif
    );

    modport slave (
        input  pixel_en, Hsync, Vsync, displayON, Xpixel, Ypixel,
               line_start, frame_start, vblank_start
`ifdef TEST_PATTERN_EN
        , input Red, Green, Blue
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator. Runs from the board clock and produces a
// one-cycle pixel enable every CLK_DIV edges instead of a derived clock.
// Optional macro TEST_PATTERN_EN adds an 8-bar colour test pattern.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic              CLK,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          H_ASSERT = 1'(H_POL);
    localparam logic          V_ASSERT = 1'(V_POL);

    logic [DW-1:0] div_cnt;
    logic [XW-1:0] hcnt, hcnt_nxt;
    logic [YW-1:0] vcnt, vcnt_nxt;
    logic          tick;
    logic          disp_nxt;

    logic          pixel_en_q, hsync_q, vsync_q, disp_q;
    logic          line_q, frame_q, vblank_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    assign tick = (div_cnt == DIV_LAST);

    // Next counter position, used only on a tick; outputs decode this value
    // so they change on the tick edge with no extra stage.
    always_comb begin
        hcnt_nxt = (hcnt == H_LAST) ? '0 : hcnt + 1'b1;
        vcnt_nxt = vcnt;
        if (hcnt == H_LAST)
            vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        disp_nxt = (hcnt_nxt < H_ACT) && (vcnt_nxt < V_ACT);
    end

    // Divider, counters and registered output decodes.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            div_cnt    <= '0;
            hcnt       <= H_LAST;
            vcnt       <= V_LAST;
            pixel_en_q <= 1'b0;
            hsync_q    <= ~H_ASSERT;
            vsync_q    <= ~V_ASSERT;
            disp_q     <= 1'b0;
            line_q     <= 1'b0;
            frame_q    <= 1'b0;
            vblank_q   <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;
            pixel_en_q <= tick;
            line_q     <= 1'b0;
            frame_q    <= 1'b0;
            vblank_q   <= 1'b0;
            if (tick) begin
                hcnt     <= hcnt_nxt;
                vcnt     <= vcnt_nxt;
                x_q      <= hcnt_nxt;
                y_q      <= vcnt_nxt;
                disp_q   <= disp_nxt;
                hsync_q  <= (hcnt_nxt >= HS_BEG && hcnt_nxt < HS_END) ? H_ASSERT : ~H_ASSERT;
                vsync_q  <= (vcnt_nxt >= VS_BEG && vcnt_nxt < VS_END) ? V_ASSERT : ~V_ASSERT;
                line_q   <= (hcnt_nxt == '0);
                frame_q  <= (hcnt_nxt == '0) && (vcnt_nxt == '0);
                vblank_q <= (hcnt_nxt == '0) && (vcnt_nxt == V_ACT);
            end
        end
    end

`ifdef TEST_PATTERN_EN
    localparam logic [XW+2:0] H_ACT_W = (XW+3)'(H_ACTIVE);
    logic [2:0] bar;
    logic [3:0] red_q, green_q, blue_q;

    // Bar index across the visible width; only meaningful while active.
    assign bar = 3'({hcnt_nxt, 3'b000} / H_ACT_W);

    // Colour bars, forced black outside the active area.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            red_q   <= 4'h0;
            green_q <= 4'h0;
            blue_q  <= 4'h0;
        end else if (tick) begin
            red_q   <= (disp_nxt && bar[2]) ? 4'hF : 4'h0;
            green_q <= (disp_nxt && bar[1]) ? 4'hF : 4'h0;
            blue_q  <= (disp_nxt && bar[0]) ? 4'hF : 4'h0;
        end
    end

    assign vga.Red   = red_q;
    assign vga.Green = green_q;
    assign vga.Blue  = blue_q;
`endif

    assign vga.pixel_en     = pixel_en_q;
    assign vga.Hsync        = hsync_q;
    assign vga.Vsync        = vsync_q;
    assign vga.displayON    = disp_q;
    assign vga.Xpixel       = x_q;
    assign vga.Ypixel       = y_q;
    assign vga.line_start   = line_q;
    assign vga.frame_start  = frame_q;
    assign vga.vblank_start = vblank_q;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 controller and the toggle-flop pixel clock used by the game top level. It runs from the board clock and divides it internally into a one-cycle pixel enable, so no derived clock is needed. It generates H/V counters, sync pulses with selectable polarity, the display-active flag, and line, frame and vblank strobes for game logic. It sits between the board top and pixel generators such as pong.

Parameters:
CLK_DIV, 2, board clocks per pixel (>=1); 2 gives 25 MHz from CLOCK_50
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, Hsync asserted level (0 = active-low)
V_POL, 0, Vsync asserted level
XW, 10, Xpixel width; must hold H_TOTAL-1
YW, 10, Ypixel width; must hold V_TOTAL-1

Ports:
CLK  in  1  board clock
reset  in  1  synchronous, active-low reset
pixel_en  out  1  one-CLK pulse per pixel; new pixel values valid while high
Hsync  out  1  horizontal sync, polarity H_POL
Vsync  out  1  vertical sync, polarity V_POL
displayON  out  1  high when the current pixel is in the active area
Xpixel  out  XW  current column
Ypixel  out  YW  current line
line_start  out  1  one-CLK pulse coincident with pixel_en when Xpixel becomes 0
frame_start  out  1  one-CLK pulse coincident with pixel_en at (0,0)
vblank_start  out  1  one-CLK pulse coincident with pixel_en at (0,V_ACTIVE); game update tick

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider div_cnt counts 0..CLK_DIV-1 and wraps. The wrap edge is a "tick". With CLK_DIV=1, every edge is a tick.
- On a tick:
  - hcnt advances and wraps from H_TOTAL-1 to 0.
  - On an hcnt wrap, vcnt advances and wraps from V_TOTAL-1 to 0.
  - All outputs register decodes of the new counter values on the same edge.
  - pixel_en is 1 for the following CLK cycle only.
- Between ticks, all outputs hold. Strobes are 0 except on the pixel_en cycle.
- Decodes:
  - displayON = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE).
  - Hsync is asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); Vsync likewise on vcnt. Deasserted level is the inverse of the polarity parameter.
  - Xpixel=hcnt and Ypixel=vcnt at all times, including blanking.
- Reset (reset==0 at a CLK edge), applied at any time including mid-frame or mid-divide:
  - div_cnt=0, hcnt=H_TOTAL-1, vcnt=V_TOTAL-1.
  - pixel_en, displayON and all strobes = 0; Xpixel=Ypixel=0; syncs deasserted.
- After release, the first tick lands on the CLK_DIV-th edge. It presents (0,0) with frame_start, line_start and displayON all 1.
- Latency: outputs change on the tick edge itself; there is no extra pipeline stage.

Optional Feature:
TEST_PATTERN_EN:
- Defined: adds outputs Red, Green, Blue (4 bits each), registered alongside the other outputs on the tick.
- Pattern: bar = hcnt*8/H_ACTIVE (0..7). Red=4'hF if bar[2], Green=4'hF if bar[1], Blue=4'hF if bar[0], else 4'h0.
- All three colour outputs are 0 when displayON is 0 and during reset.
- Undefined: the three ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Defaults, hold reset low 5 cycles then release -> all outputs at reset values during reset; pixel_en first high after the 2nd edge post-release, with Xpixel=0, Ypixel=0, frame_start=1, line_start=1, displayON=1.
2. Run one line -> Hsync=0 exactly for Xpixel 656..751 (96 ticks); displayON=0 for Xpixel 640..799; Xpixel wraps 799->0 with line_start and Ypixel incremented.
3. Run two frames -> 420000 ticks (840000 CLK) between frame_start pulses; Vsync=0 only on lines 490..491; vblank_start once per frame at (0,480).
4. Assert reset at (300,200) mid-divide -> next cycle pixel_en=0, Xpixel=Ypixel=0, syncs high; after release, restart at (0,0) with frame_start.
5. CLK_DIV=1, H_POL=1 -> pixel_en continuously 1 after release; Hsync=1 for Xpixel 656..751 and 0 elsewhere.
6. TEST_PATTERN_EN, defaults -> Xpixel 0..79 gives RGB 0/0/0; 80..159 gives B=F; 560..639 gives all F; Xpixel 640 or Ypixel 480 gives all 0.
